// File: rtl/mac_cfg_loader_pkg.sv
// Shared MAC constants: datapath widths and the mode codes carried in the conf field.
// Loaders and the MAC block import this package so both sides agree on the cfg word layout.
package mac_cfg_loader_pkg;

    localparam int MAC_ACC_WIDTH  = 32;
    localparam int MAC_CONF_WIDTH = 3;

    // conf[0] enables accumulation, conf[1] selects the cascade input
    localparam logic [MAC_CONF_WIDTH-1:0] MODE_SINGLE    = 3'b000;
    localparam logic [MAC_CONF_WIDTH-1:0] MODE_ACCUM     = 3'b001;
    localparam logic [MAC_CONF_WIDTH-1:0] MODE_CASCADE   = 3'b010;
    localparam logic [MAC_CONF_WIDTH-1:0] MODE_CASC_ACCUM = 3'b011;

endpackage

// File: rtl/mac_cfg_loader.sv
// Serial configuration loader for one MAC block: shifts a cfg word in MSB first,
// commits it atomically and gates the MAC enable around each load.
module mac_cfg_loader
    import mac_cfg_loader_pkg::*;
#(
    parameter int ACC_W  = MAC_ACC_WIDTH,
    parameter int CONF_W = MAC_CONF_WIDTH,
    localparam int CFG_W = ACC_W + CONF_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_in,
    input  logic             cfg_shift,
    input  logic             cfg_commit,
    input  logic             run,
    output logic [CFG_W-1:0] cfg_out,
    output logic             mac_en,
    output logic             cfg_update,
    output logic             scan_out,
    output logic             busy,
    output logic             load_err
);

    localparam int CNT_W = $clog2(CFG_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [CFG_W-1:0] sr_r, sr_nxt_s;
    logic [CFG_W-1:0] cfg_out_r, cfg_out_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic             cfg_valid_r, cfg_valid_nxt_s;
    logic             cfg_update_r, cfg_update_nxt_s;
    logic             scan_out_r, scan_out_nxt_s;
    logic             load_err_r, load_err_nxt_s;
    logic             mac_en_r, mac_en_nxt_s;
    logic             busy_r;
    logic             good_commit_s;

    // Next-state logic for the shift chain, bit counter, commit handling and FSM
    always_comb begin
        state_nxt_s      = state_r;
        sr_nxt_s         = sr_r;
        cfg_out_nxt_s    = cfg_out_r;
        cnt_nxt_s        = cnt_r;
        cfg_valid_nxt_s  = cfg_valid_r;
        cfg_update_nxt_s = 1'b0;
        scan_out_nxt_s   = scan_out_r;
        load_err_nxt_s   = load_err_r;
        mac_en_nxt_s     = 1'b0;

        // A commit is only clean when the full word is in and no shift collides with it
        good_commit_s = cfg_commit && !cfg_shift && (cnt_r == CNT_FULL);

        if (cfg_shift) begin
            sr_nxt_s       = {sr_r[CFG_W-2:0], cfg_in};
            scan_out_nxt_s = sr_r[CFG_W-1];
            if (cnt_r != CNT_FULL) begin
                cnt_nxt_s = cnt_r + CNT_ONE;
            end else begin
                cnt_nxt_s = cnt_r;
            end
        end else begin
            sr_nxt_s       = sr_r;
            scan_out_nxt_s = scan_out_r;
        end

        if (cfg_commit) begin
            cnt_nxt_s = '0;
            if (good_commit_s) begin
                cfg_out_nxt_s    = sr_r;
                cfg_update_nxt_s = 1'b1;
                cfg_valid_nxt_s  = 1'b1;
            end else begin
                load_err_nxt_s = 1'b1;
            end
        end else begin
            cfg_update_nxt_s = 1'b0;
        end

        case (state_r)
            ST_IDLE: begin
                if (cfg_shift && !cfg_commit) begin
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cfg_commit) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase

        // Hold the MAC off through the load and the update cycle so it picks up the new init value
        mac_en_nxt_s = run && cfg_valid_nxt_s && (state_nxt_s == ST_IDLE) && !cfg_update_nxt_s;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            sr_r         <= '0;
            cfg_out_r    <= '0;
            cnt_r        <= '0;
            cfg_valid_r  <= 1'b0;
            cfg_update_r <= 1'b0;
            scan_out_r   <= 1'b0;
            load_err_r   <= 1'b0;
            mac_en_r     <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            sr_r         <= sr_nxt_s;
            cfg_out_r    <= cfg_out_nxt_s;
            cnt_r        <= cnt_nxt_s;
            cfg_valid_r  <= cfg_valid_nxt_s;
            cfg_update_r <= cfg_update_nxt_s;
            scan_out_r   <= scan_out_nxt_s;
            load_err_r   <= load_err_nxt_s;
            mac_en_r     <= mac_en_nxt_s;
            busy_r       <= (state_nxt_s == ST_SHIFT);
        end
    end

    assign cfg_out    = cfg_out_r;
    assign mac_en     = mac_en_r;
    assign cfg_update = cfg_update_r;
    assign scan_out   = scan_out_r;
    assign busy       = busy_r;
    assign load_err   = load_err_r;

endmodule

// File: tb/tb_mac_cfg_loader.sv
// Self-checking bench for mac_cfg_loader: directed vector table, hand sequences
// for enable gating and reset, and randomized traffic against a bit-history model.
module tb_mac_cfg_loader;

    localparam int CFG_W = 35;

    logic             clk = 1'b0;
    logic             rst, cfg_in, cfg_shift, cfg_commit, run;
    logic [CFG_W-1:0] cfg_out;
    logic             mac_en, cfg_update, scan_out, busy, load_err;

    int checks   = 0;
    int failures = 0;

    mac_cfg_loader #(.ACC_W(32), .CONF_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_in     (cfg_in),
        .cfg_shift  (cfg_shift),
        .cfg_commit (cfg_commit),
        .run        (run),
        .cfg_out    (cfg_out),
        .mac_en     (mac_en),
        .cfg_update (cfg_update),
        .scan_out   (scan_out),
        .busy       (busy),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cfg_shift  = 1'b0;
        cfg_commit = 1'b0;
        cfg_in     = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        run = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cfg_out"},    64'(cfg_out),    64'h0);
        chk({tag, "_mac_en"},     64'(mac_en),     64'h0);
        chk({tag, "_cfg_update"}, 64'(cfg_update), 64'h0);
        chk({tag, "_scan_out"},   64'(scan_out),   64'h0);
        chk({tag, "_busy"},       64'(busy),       64'h0);
        chk({tag, "_load_err"},   64'(load_err),   64'h0);
    endtask

    typedef struct {
        bit              rst_first;
        int              nshift;
        logic [39:0]     pat;
        bit              commit_on_last;
        logic [CFG_W-1:0] exp_cfg;
        bit              exp_upd;
        bit              exp_err;
    } vec_t;

    vec_t vecs[5];

    // reference model state
    bit               hist[$];
    int               m_cnt;
    bit               m_loading, m_valid, m_err, m_upd, m_mac, m_scan;
    logic [CFG_W-1:0] m_cfg;

    task automatic model_reset();
        hist.delete();
        m_cnt = 0; m_loading = 0; m_valid = 0; m_err = 0;
        m_upd = 0; m_mac = 0; m_scan = 0; m_cfg = '0;
    endtask

    initial begin
        rst = 1'b0;
        run = 1'b0;
        idle_inputs();

        vecs[0] = '{1'b1, 35, 40'h00_0000_0105, 1'b0, 35'h0_0000_0105, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 34, 40'h03_FFFF_FFFF, 1'b0, 35'h0_0000_0105, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 35, 40'h05_A5A5_A5A5, 1'b0, 35'h5_A5A5_A5A5, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 40, 40'hA8_1234_5678, 1'b0, 35'h0_1234_5678, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 35, 40'h07_0000_0001, 1'b1, 35'h0_1234_5678, 1'b0, 1'b1};

        do_reset();
        chk_all_zero("reset");

        for (int v = 0; v < 5; v++) begin
            if (vecs[v].rst_first) do_reset();
            for (int k = 1; k <= vecs[v].nshift; k++) begin
                cfg_in     = vecs[v].pat[vecs[v].nshift - k];
                cfg_shift  = 1'b1;
                cfg_commit = vecs[v].commit_on_last && (k == vecs[v].nshift);
                tick();
                if (vecs[v].rst_first) begin
                    if (k > CFG_W)
                        chk($sformatf("v%0d_scan_k%0d", v, k), 64'(scan_out),
                            64'(vecs[v].pat[vecs[v].nshift - 1 - (k - CFG_W - 1)]));
                    else
                        chk($sformatf("v%0d_scan_k%0d", v, k), 64'(scan_out), 64'h0);
                end
            end
            if (!vecs[v].commit_on_last) begin
                cfg_shift  = 1'b0;
                cfg_commit = 1'b1;
                tick();
            end
            idle_inputs();
            chk($sformatf("v%0d_cfg_out", v),    64'(cfg_out),    64'(vecs[v].exp_cfg));
            chk($sformatf("v%0d_cfg_update", v), 64'(cfg_update), 64'(vecs[v].exp_upd));
            chk($sformatf("v%0d_load_err", v),   64'(load_err),   64'(vecs[v].exp_err));
            chk($sformatf("v%0d_busy", v),       64'(busy),       64'h0);
            tick();
            chk($sformatf("v%0d_upd_gone", v),   64'(cfg_update), 64'h0);
            chk($sformatf("v%0d_cfg_hold", v),   64'(cfg_out),    64'(vecs[v].exp_cfg));
        end

        // Enable gating across a full load with run held high
        do_reset();
        run = 1'b1;
        tick();
        chk("gate_no_valid", 64'(mac_en), 64'h0);
        for (int k = 0; k < CFG_W; k++) begin
            cfg_in    = k[0];
            cfg_shift = 1'b1;
            tick();
            chk($sformatf("gate_busy_k%0d", k),  64'(busy),   64'h1);
            chk($sformatf("gate_mac_k%0d", k),   64'(mac_en), 64'h0);
        end
        cfg_shift  = 1'b0;
        cfg_commit = 1'b1;
        tick();
        idle_inputs();
        chk("gate_upd_cycle_upd", 64'(cfg_update), 64'h1);
        chk("gate_upd_cycle_mac", 64'(mac_en),     64'h0);
        chk("gate_upd_cycle_busy", 64'(busy),      64'h0);
        tick();
        chk("gate_after_mac", 64'(mac_en),     64'h1);
        chk("gate_after_upd", 64'(cfg_update), 64'h0);
        run = 1'b0;
        tick();
        chk("gate_run_low", 64'(mac_en), 64'h0);

        // Reset in the middle of a load discards everything
        for (int k = 0; k < 20; k++) begin
            cfg_in    = 1'b1;
            cfg_shift = 1'b1;
            tick();
        end
        rst = 1'b1;
        idle_inputs();
        tick();
        rst = 1'b0;
        chk_all_zero("midrst");
        cfg_commit = 1'b1;
        tick();
        idle_inputs();
        chk("midrst_commit_err", 64'(load_err),   64'h1);
        chk("midrst_commit_upd", 64'(cfg_update), 64'h0);
        chk("midrst_commit_cfg", 64'(cfg_out),    64'h0);

        // Randomized traffic against the bit-history model
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            bit sh, cm, rn, bi, rr;
            sh = ($urandom_range(0, 3) != 0);
            cm = (m_cnt == CFG_W) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 39) == 0);
            rn = ($urandom_range(0, 3) != 0);
            bi = 1'($urandom_range(0, 1));
            rr = ($urandom_range(0, 299) == 0);
            rst = rr; cfg_shift = sh; cfg_commit = cm; run = rn; cfg_in = bi;
            tick();
            if (rr) begin
                model_reset();
            end else begin
                m_upd = 0;
                if (sh) begin
                    hist.push_back(bi);
                    m_scan = (hist.size() > CFG_W) ? hist[hist.size() - CFG_W - 1] : 1'b0;
                    if (hist.size() > CFG_W + 1) void'(hist.pop_front());
                    if (m_cnt < CFG_W) m_cnt++;
                end
                if (cm) begin
                    if (!sh && m_cnt == CFG_W) begin
                        for (int i = 0; i < CFG_W; i++) begin
                            int idx;
                            idx = hist.size() - 1 - i;
                            m_cfg[i] = (idx >= 0) ? hist[idx] : 1'b0;
                        end
                        m_upd   = 1;
                        m_valid = 1;
                    end else begin
                        m_err = 1;
                    end
                    m_cnt     = 0;
                    m_loading = 0;
                end else if (sh) begin
                    m_loading = 1;
                end
                m_mac = rn && m_valid && !m_loading && !m_upd;
            end
            chk($sformatf("rnd%0d_cfg_out", c),    64'(cfg_out),    64'(m_cfg));
            chk($sformatf("rnd%0d_cfg_update", c), 64'(cfg_update), 64'(m_upd));
            chk($sformatf("rnd%0d_load_err", c),   64'(load_err),   64'(m_err));
            chk($sformatf("rnd%0d_busy", c),       64'(busy),       64'(m_loading));
            chk($sformatf("rnd%0d_mac_en", c),     64'(mac_en),     64'(m_mac));
            chk($sformatf("rnd%0d_scan_out", c),   64'(scan_out),   64'(m_scan));
        end
        rst = 1'b0;
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
